// File: rtl/gpr_pkg.sv
// gpr_pkg: shared write-back sizing, requester ids and pointer-width helper
package gpr_pkg;
  localparam int NREQ = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_MDU = 2;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gpr_wb_arb_rr_pick.sv
// rr_pick: one-hot pick of the first valid requester searching upward from ptr with wrap
module rr_pick #(
  parameter int N = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  int idx;
  // walk the rotation from farthest to nearest so the nearest valid overwrites
  always_comb begin
    grant = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (valid[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb: register-file write-back arbiter; define GPR_WB_RR_EN for round-robin, otherwise fixed priority
module gpr_wb_arb
  import gpr_pkg::ptr_w;
#(
  parameter int NREQ = gpr_pkg::NREQ,
  parameter int DW = gpr_pkg::DW,
  parameter int AW = gpr_pkg::AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rw,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               wb_en,
  output logic [AW-1:0]      wb_rw,
  output logic [DW-1:0]      wb_data,
  output logic [15:0]        wb_count
);
  localparam int PW = ptr_w(NREQ);
  logic [NREQ-1:0] grant;
  logic [PW-1:0] ptr;
  logic wb_en_q, wb_en_d;
  logic [AW-1:0] wb_rw_q, wb_rw_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [15:0] cnt_q, cnt_d;
`ifdef GPR_WB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif
  rr_pick #(.N(NREQ), .PW(PW)) u_pick (.valid(req_valid), .ptr(ptr), .grant(grant));
  assign req_ready = (rst || hold) ? '0 : grant;
  assign wb_en = wb_en_q;
  assign wb_rw = wb_rw_q;
  assign wb_data = wb_data_q;
  assign wb_count = cnt_q;
  // mux the accepted request into the write-back stage; index 0 is consumed silently
  always_comb begin
    wb_en_d = 1'b0;
    wb_rw_d = wb_rw_q;
    wb_data_d = wb_data_q;
`ifdef GPR_WB_RR_EN
    ptr_d = ptr_q;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        wb_en_d = |req_rw[i*AW +: AW];
        wb_rw_d = wb_en_d ? req_rw[i*AW +: AW] : wb_rw_q;
        wb_data_d = wb_en_d ? req_data[i*DW +: DW] : wb_data_q;
`ifdef GPR_WB_RR_EN
        ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
`endif
      end
    end
    cnt_d = cnt_q + 16'(wb_en_d);
  end
  // write-back stage registers; reset drops any write still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q <= 1'b0;
      wb_rw_q <= '0;
      wb_data_q <= '0;
      cnt_q <= '0;
`ifdef GPR_WB_RR_EN
      ptr_q <= '0;
`endif
    end else begin
      wb_en_q <= wb_en_d;
      wb_rw_q <= wb_rw_d;
      wb_data_q <= wb_data_d;
      cnt_q <= cnt_d;
`ifdef GPR_WB_RR_EN
      ptr_q <= ptr_d;
`endif
    end
  end
endmodule
